// File: rtl/subckt_activity_probe_pkg.sv
// Shared types, constants and helpers for the sub-circuit activity probe.
package subckt_activity_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int VEC_W = 4;

  // x^4 + x^3 + 1 on a left-shifting register: feedback is bit3 ^ bit2.
  localparam logic [VEC_W-1:0] LFSR_SEED = 4'b0001;
  localparam logic [VEC_W-1:0] LFSR_TAPS = 4'b1100;

  // Vector index counter; the last index of a run always fits in 8 bits.
  localparam int               IDX_W    = 8;
  localparam logic [IDX_W-1:0] EXH_LAST = 8'd15;

  // Result widths sized for a 256-vector run without wrap.
  localparam int ONES_W    = 9;
  localparam int OUT_TGL_W = 9;
  localparam int IN_TGL_W  = 10;
  localparam int POP_W     = 3;

  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] q);
    return {q[VEC_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [POP_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < VEC_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/subckt_vec_gen.sv
// Stimulus vector generator: binary count (mode 0) or LFSR sequence (mode 1).
// The selected vector is registered so the sub-circuit input never glitches.
module subckt_vec_gen
  import subckt_activity_probe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic             mode,
  output logic [VEC_W-1:0] vec
);

  logic [VEC_W-1:0] bin_q;
  logic [VEC_W-1:0] lfsr_q;
  logic [VEC_W-1:0] bin_nxt;
  logic [VEC_W-1:0] lfsr_nxt;

  // Successor of each generator, computed from its own state.
  always_comb begin
    bin_nxt  = bin_q + VEC_W'(1);
    lfsr_nxt = lfsr_next(lfsr_q);
  end

  // Generator state and registered output vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      lfsr_q <= LFSR_SEED;
      vec    <= '0;
    end else if (load) begin
      bin_q  <= '0;
      lfsr_q <= LFSR_SEED;
      vec    <= mode ? LFSR_SEED : '0;
    end else if (clear) begin
      bin_q  <= '0;
      lfsr_q <= LFSR_SEED;
      vec    <= '0;
    end else if (step) begin
      bin_q  <= bin_nxt;
      lfsr_q <= lfsr_nxt;
      vec    <= mode ? lfsr_nxt : bin_nxt;
    end
  end

endmodule

// File: rtl/subckt_activity_probe.sv
// Activity probe: sweeps a 4-input sub-circuit, counts ones and toggles on
// its output and toggles on its inputs, and flags constant-output circuits.
module subckt_activity_probe
  import subckt_activity_probe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [7:0]           num_vec,
  input  logic                 dut_out,
  output logic [VEC_W-1:0]     dut_in,
  output logic                 busy,
  output logic                 done,
  output logic [ONES_W-1:0]    ones_cnt,
  output logic [OUT_TGL_W-1:0] out_tgl_cnt,
  output logic [IN_TGL_W-1:0]  in_tgl_cnt,
  output logic                 const_flag,
  output logic                 const_val
);

  state_t state_q;
  state_t state_nxt;

  logic             mode_q;
  logic [IDX_W-1:0] last_idx_q;
  logic [IDX_W-1:0] idx_q;

  logic load;
  logic vld_p0;
  logic last_smp;
  logic step;
  logic first_smp;
  logic gen_mode;

  logic             out_prev_p1;
  logic [VEC_W-1:0] vec_prev_p1;

  logic [OUT_TGL_W-1:0] out_tgl_nxt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_nxt = ST_RUN;
      ST_RUN:  if (last_smp) state_nxt = ST_FIN;
      ST_FIN:                state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs and per-cycle control strobes decoded from the state.
  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_FIN);
    load      = (state_q == ST_IDLE) && start;
    vld_p0    = busy;
    last_smp  = vld_p0 && (idx_q == last_idx_q);
    step      = vld_p0 && !last_smp;
    first_smp = (idx_q == '0);
    gen_mode  = load ? mode : mode_q;
  end

  subckt_vec_gen u_vec_gen (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .step  (step),
    .clear (last_smp),
    .mode  (gen_mode),
    .vec   (dut_in)
  );

  // Output-toggle count including the sample taken on this edge.
  always_comb begin
    out_tgl_nxt = out_tgl_cnt
                + OUT_TGL_W'(!first_smp && (dut_out != out_prev_p1));
  end

  // Run configuration and result accumulation; sample p0 -> history p1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      last_idx_q  <= '0;
      idx_q       <= '0;
      ones_cnt    <= '0;
      out_tgl_cnt <= '0;
      in_tgl_cnt  <= '0;
      const_flag  <= 1'b0;
      const_val   <= 1'b0;
      out_prev_p1 <= 1'b0;
      vec_prev_p1 <= '0;
    end else if (load) begin
      mode_q      <= mode;
      // num_vec = 0 wraps to 255, i.e. a 256-vector run.
      last_idx_q  <= mode ? (num_vec - 8'd1) : EXH_LAST;
      idx_q       <= '0;
      ones_cnt    <= '0;
      out_tgl_cnt <= '0;
      in_tgl_cnt  <= '0;
      const_flag  <= 1'b0;
      const_val   <= 1'b0;
      out_prev_p1 <= 1'b0;
      vec_prev_p1 <= '0;
    end else if (vld_p0) begin
      idx_q       <= idx_q + IDX_W'(1);
      ones_cnt    <= ones_cnt + ONES_W'(dut_out);
      out_tgl_cnt <= out_tgl_nxt;
      out_prev_p1 <= dut_out;
      vec_prev_p1 <= dut_in;
      if (first_smp) begin
        const_val <= dut_out;
      end else begin
        in_tgl_cnt <= in_tgl_cnt + IN_TGL_W'(popcount(dut_in ^ vec_prev_p1));
      end
      if (last_smp) begin
        const_flag <= (out_tgl_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_subckt_activity_probe.sv
// Self-checking bench for subckt_activity_probe: table of directed runs,
// hand-written restart/reset sequences, and randomized runs against a model.
module tb_subckt_activity_probe;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] num_vec;
  logic       dut_out;
  logic [3:0] dut_in;
  logic       busy;
  logic       done;
  logic [8:0] ones_cnt;
  logic [8:0] out_tgl_cnt;
  logic [9:0] in_tgl_cnt;
  logic       const_flag;
  logic       const_val;

  // Truth table of the emulated sub-circuit, indexed by its input vector.
  logic [15:0] tt;
  assign dut_out = tt[dut_in];

  subckt_activity_probe dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mode        (mode),
    .num_vec     (num_vec),
    .dut_out     (dut_out),
    .dut_in      (dut_in),
    .busy        (busy),
    .done        (done),
    .ones_cnt    (ones_cnt),
    .out_tgl_cnt (out_tgl_cnt),
    .in_tgl_cnt  (in_tgl_cnt),
    .const_flag  (const_flag),
    .const_val   (const_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model results.
  int         exp_n, exp_ones, exp_otgl, exp_itgl;
  logic       exp_cf, exp_cv;
  logic [3:0] expv[256];

  // Period-15 sequence of x^4+x^3+1 from seed 0001 (bit3^bit2 shifted in at bit0).
  int lfsr_seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};

  typedef struct {
    logic        m;
    logic [7:0]  nv;
    logic [15:0] t;
    int          n, ones, otgl, itgl;
    logic        cf, cv;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input logic m, input logic [7:0] nv, input logic [15:0] t);
    int   n, v, pv;
    logic o, po;
    n = m ? ((nv == 0) ? 256 : int'(nv)) : 16;
    exp_n = n; exp_ones = 0; exp_otgl = 0; exp_itgl = 0;
    pv = 0; po = 1'b0; exp_cv = 1'b0;
    for (int k = 0; k < n; k++) begin
      v = m ? lfsr_seq[k % 15] : k;
      expv[k] = 4'(v);
      o = t[v];
      if (o) exp_ones++;
      if (k == 0) exp_cv = o;
      else begin
        if (o != po) exp_otgl++;
        exp_itgl += $countones(4'(v ^ pv));
      end
      pv = v; po = o;
    end
    exp_cf = (exp_otgl == 0);
  endtask

  task automatic run_and_check(input string name, input logic m, input logic [7:0] nv,
                               input logic [15:0] t, input int e_n, input int e_ones,
                               input int e_otgl, input int e_itgl, input logic e_cf,
                               input logic e_cv, input int restart_at, input bit fin_poke);
    int busy_cyc, done_cnt, vec_err, din_err, post, post_busy;
    bit done_seen;
    model(m, nv, t);
    busy_cyc = 0; done_cnt = 0; vec_err = 0; din_err = 0; post = 0; post_busy = 0;
    done_seen = 0;
    tt = t; mode = m; num_vec = nv; start = 1'b1;
    for (int c = 0; c < 700 && post < 3; c++) begin
      @(negedge clk);
      if (busy) begin
        if (busy_cyc < 256 && dut_in !== expv[busy_cyc]) vec_err++;
        busy_cyc++;
        if (done_seen) post_busy++;
      end
      if (done) begin
        done_cnt++;
        if (dut_in !== 4'd0) din_err++;
      end
      start = 1'b0;
      if (restart_at >= 0 && busy && busy_cyc == restart_at) start = 1'b1;
      if (done && fin_poke) start = 1'b1;
      if (done_seen) post++;
      if (done) done_seen = 1;
    end
    start = 1'b0;
    check({name, ".finished"}, 32'(done_seen), 32'd1);
    check({name, ".busy_cycles"}, busy_cyc, e_n);
    check({name, ".done_pulses"}, done_cnt, 1);
    check({name, ".vector_errs"}, vec_err, 0);
    check({name, ".dut_in_at_done"}, din_err, 0);
    check({name, ".busy_after"}, post_busy, 0);
    check({name, ".ones_cnt"}, 32'(ones_cnt), e_ones);
    check({name, ".out_tgl_cnt"}, 32'(out_tgl_cnt), e_otgl);
    check({name, ".in_tgl_cnt"}, 32'(in_tgl_cnt), e_itgl);
    check({name, ".const_flag"}, 32'(const_flag), 32'(e_cf));
    check({name, ".const_val"}, 32'(const_val), 32'(e_cv));
  endtask

  task automatic check_zero(input string name);
    check({name, ".busy"}, 32'(busy), 0);
    check({name, ".done"}, 32'(done), 0);
    check({name, ".dut_in"}, 32'(dut_in), 0);
    check({name, ".ones_cnt"}, 32'(ones_cnt), 0);
    check({name, ".out_tgl_cnt"}, 32'(out_tgl_cnt), 0);
    check({name, ".in_tgl_cnt"}, 32'(in_tgl_cnt), 0);
    check({name, ".const_flag"}, 32'(const_flag), 0);
    check({name, ".const_val"}, 32'(const_val), 0);
  endtask

  initial begin
    logic        rm;
    logic [7:0]  rnv;
    logic [15:0] rt;

    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; num_vec = 8'd0; tt = 16'h0000;

    //            mode  num_vec  truth     N    ones otgl itgl cf    cv
    tbl[0] = '{1'b0, 8'd0,   16'h0000, 16,  0,   0,   26,  1'b1, 1'b0};
    tbl[1] = '{1'b0, 8'd0,   16'h6996, 16,  8,   10,  26,  1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'd15,  16'hAAAA, 15,  8,   7,   30,  1'b0, 1'b1};
    tbl[3] = '{1'b1, 8'd0,   16'hFFFF, 256, 256, 0,   544, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 8'd77,  16'hAAAA, 16,  8,   15,  26,  1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'd1,   16'hFFFF, 1,   1,   0,   0,   1'b1, 1'b1};
    tbl[6] = '{1'b1, 8'd16,  16'h0001, 16,  0,   0,   32,  1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    for (int i = 0; i < 7; i++) begin
      run_and_check($sformatf("tbl%0d", i), tbl[i].m, tbl[i].nv, tbl[i].t, tbl[i].n,
                    tbl[i].ones, tbl[i].otgl, tbl[i].itgl, tbl[i].cf, tbl[i].cv, -1, 0);
      repeat (2) @(negedge clk);
    end

    // Second start on cycle 5 of a mode-0 run must be ignored.
    run_and_check("restart5", 1'b0, 8'd0, 16'h6996, 16, 8, 10, 26, 1'b0, 1'b0, 5, 0);
    // Start presented during FIN must be ignored.
    run_and_check("fin_start", 1'b0, 8'd0, 16'h0000, 16, 0, 0, 26, 1'b1, 1'b0, -1, 1);

    // Reset on cycle 7 of a run clears everything asynchronously.
    tt = 16'hFFFF; mode = 1'b0; num_vec = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrun.busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_zero("midrun_rst_async");
    @(negedge clk);
    check_zero("midrun_rst_held");
    rst = 1'b0;
    @(negedge clk);
    run_and_check("after_rst", 1'b0, 8'd0, 16'h0000, 16, 0, 0, 26, 1'b1, 1'b0, -1, 0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 12; r++) begin
      rm  = 1'($urandom_range(0, 1));
      rnv = 8'($urandom_range(0, 255));
      rt  = 16'($urandom);
      if (r == 0) rt = 16'h0000;
      model(rm, rnv, rt);
      run_and_check($sformatf("rand%0d", r), rm, rnv, rt, exp_n, exp_ones, exp_otgl,
                    exp_itgl, exp_cf, exp_cv, -1, 0);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subckt_activity_probe.md
SUBCKT_ACTIVITY_PROBE -- requirements
Module: subckt_activity_probe

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  one-cycle request to begin a measurement run; sampled only in IDLE.
REQ-004 mode  input  1  0 = exhaustive binary sweep, 16 vectors; 1 = pseudo-random LFSR sweep.
REQ-005 num_vec  input  8  vector count for mode 1; 0 means 256; ignored in mode 0.
REQ-006 dut_out  input  1  combinational output of the 4-input sub-circuit under test.
REQ-007 dut_in  output  4  stimulus to the sub-circuit; bit0..bit3 drive n_1..n_4.
REQ-008 busy  output  1  high while vectors are being applied.
REQ-009 done  output  1  one-cycle pulse when results are valid.
REQ-010 ones_cnt  output  9  number of sampled vectors with dut_out=1.
REQ-011 out_tgl_cnt  output  9  dut_out changes between consecutive samples.
REQ-012 in_tgl_cnt  output  10  sum of popcount(dut_in XOR previous dut_in) over consecutive vectors.
REQ-013 const_flag  output  1  1 when out_tgl_cnt=0 at end of run ("no power" sub-circuit).
REQ-014 const_val  output  1  dut_out value of first sample; meaningful when const_flag=1.

Function
REQ-015 FSM states IDLE, RUN, FIN; IDLE->RUN on start=1; RUN->FIN after last vector sampled; FIN->IDLE unconditionally next cycle.
REQ-016 On start acceptance, the module SHALL clear all counters, const_flag and const_val, latch mode and num_vec, and load vector 0 into dut_in on that same edge.
REQ-017 Mode 0 vectors SHALL be 0,1,...,15 in order; mode 1 vectors SHALL be successive states of a 4-bit Fibonacci LFSR, x^4+x^3+1, seed 4'b0001, first vector = seed.
REQ-018 Each vector SHALL be held exactly one RUN cycle; dut_out SHALL be sampled at the edge ending that cycle, when the next vector is also loaded.
REQ-019 Run length SHALL be N = 16 (mode 0) or num_vec/256 (mode 1); busy high for exactly N cycles; done high the single cycle after the last sample (state FIN).
REQ-020 Toggle counters SHALL not count the first sample; counters SHALL be wide enough not to saturate at N=256.
REQ-021 After the last sample dut_in SHALL return to 0; results SHALL hold from FIN until the next accepted start.
REQ-022 start while busy or in FIN SHALL be ignored; simultaneous start and last sample SHALL not extend the run.
REQ-023 const_flag SHALL be updated at entry to FIN only.

Reset
REQ-024 rst SHALL force IDLE, dut_in=0, busy=0, done=0, all counters 0, const_flag=0, const_val=0, LFSR=seed, at any time including mid-run; no partial results survive.

Structure
REQ-025 A shared package SHALL hold the state enum, LFSR seed and tap constants, and counter width parameters.
REQ-026 The vector generator (binary counter / LFSR select) SHALL be one sub-module, subckt_vec_gen; counting and FSM remain in the top.

Verification
REQ-027 Constant-0 model (dut_out tied 0), mode 0 -> done after 16 busy cycles; ones_cnt=0, out_tgl_cnt=0, in_tgl_cnt=26, const_flag=1, const_val=0.
REQ-028 dut_out = XOR of dut_in bits, mode 0 -> ones_cnt=8, out_tgl_cnt=10, const_flag=0.
REQ-029 dut_out = dut_in[0], mode 1, num_vec=15 -> vectors cover all 15 nonzero values; ones_cnt=8, const_flag=0.
REQ-030 start pulsed again on cycle 5 of a mode-0 run -> ignored; run still ends after 16 vectors with one done pulse.
REQ-031 rst asserted on cycle 7 of a run, then start -> all outputs 0 during reset; new run gives results identical to REQ-027.
REQ-032 mode 1, num_vec=0, dut_out tied 1 -> busy 256 cycles; ones_cnt=256, out_tgl_cnt=0, const_flag=1, const_val=1.
